l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
Round-robin arbiter and sequencer for the shared L2 cache port. Requesters are the I-cache, the D-cache and a next-line prefetcher (index 0/1/2).
Grants one requester at a time, latches its address and write data, and drives the L2 read/write strobes until mem_resp. It then returns a one-cycle response to the granted requester only.
Sits between the L1 caches/prefetcher and l2_cache. Its busy output feeds pipeline stall logic.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
ADDR_W, 16, address width (lc3b_word)
BLOCK_W, 128, cache line width (lc3b_c_block)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_read  in  NUM_REQ  per-requester read request, level, held until req_resp
req_write  in  NUM_REQ  per-requester write request, level, held until req_resp
req_address  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*BLOCK_W  packed write lines
req_resp  out  NUM_REQ  one-hot one-cycle completion pulse
req_rdata  out  BLOCK_W  read line, broadcast; valid while req_resp asserted
l2_address  out  ADDR_W  latched address to L2
l2_wdata  out  BLOCK_W  latched write line to L2
l2_read  out  1  L2 read strobe
l2_write  out  1  L2 write strobe
l2_rdata  in  BLOCK_W  L2 read data
l2_resp  in  1  L2 completion
busy  out  1  high whenever FSM not IDLE
grant_id  out  2  index of current/last granted requester

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FSM=IDLE, rr_ptr=0, grant_id=0.
  - All strobes, req_resp and busy = 0.
  - l2_address and l2_wdata = 0.
- Valid request from i: req_read[i] | req_write[i].
- FSM states:
  - IDLE: if any valid request, pick winner w = first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - Latch address, wdata and op (write wins if both read and write set) into registers.
    - grant_id <= w; next state ACCESS. No request -> stay IDLE.
  - ACCESS: l2_read or l2_write = latched op, driven from registers.
    - l2_resp=1 -> req_resp[w]=1 that same cycle; req_rdata = l2_rdata combinationally; next state RELEASE.
    - Otherwise hold.
  - RELEASE: all strobes 0, req_resp 0; rr_ptr <= (w+1) mod NUM_REQ; next state IDLE.
    - Gives L2 and the requester one dead cycle to deassert.
- Latency: request seen in IDLE at cycle t -> L2 strobe at t+1 -> resp in the cycle of l2_resp -> earliest next grant at resp+2.
  - Minimum back-to-back spacing is 3 cycles plus L2 latency.
- Requests arriving during ACCESS/RELEASE wait; they are not lost because requests are level.
- Request withdrawn while not granted: simply not considered.
- Request withdrawn while granted: illegal. The arbiter completes the L2 access and still pulses req_resp.
- l2_resp outside ACCESS: ignored.
- Reset during ACCESS: transaction abandoned, strobes drop next edge. l2_cache is reset by the same rst.
- grant_id holds its value through RELEASE and IDLE.
- Index arithmetic is modulo NUM_REQ; the pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
L2_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins in IDLE; rr_ptr is not instantiated and stays 0.
- Undefined: round-robin as above.
- Handshake, latency and FSM are identical in both builds.

Decomposition:
- lc3b_types gains:
  - l2_arb_state_t enum (IDLE, ACCESS, RELEASE).
  - Constants L2_REQ_ICACHE=0, L2_REQ_DCACHE=1, L2_REQ_PREFETCH=2.
- Sub-module rr_picker (combinational): request vector + pointer -> one-hot winner + index. Reused by the fixed-priority build with pointer tied to 0.

Test Plan:
- Single read: req_read[0]=1, address 0x1230; l2_resp 4 cycles after l2_read; l2_rdata=0xA5..A5 -> l2_read=1 at t+1 with l2_address=0x1230; req_resp=3'b001 for one cycle; req_rdata=0xA5..A5; busy falls after RELEASE.
- Simultaneous: req_read[0] and req_write[1] at reset-idle (rr_ptr=0) -> requester 0 served first, then requester 1 write with its wdata; grant_id sequence 0,1.
- Fairness: all three requesting continuously for 6 transactions -> grant order 0,1,2,0,1,2; no requester granted twice before the others are served.
- Read and write both set on requester 1 -> only l2_write asserted, address from slot 1, req_resp=3'b010.
- Reset mid-ACCESS (rst 2 cycles after l2_read rises) -> next edge: l2_read=0, busy=0, rr_ptr=0; a stale l2_resp after reset produces no req_resp.
- Build with L2_ARB_FIXED_PRIO_EN, all three requesting continuously -> grants 0,0,0 until requester 0 drops, then 1.

Source files
------------

// File: rtl/l2_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_req_arbiter_pkg
// Description : Shared types and constants for the L2 request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_req_arbiter_pkg;

    localparam int IDX_W = 2;

    localparam logic [IDX_W-1:0] L2_REQ_ICACHE   = 2'd0;
    localparam logic [IDX_W-1:0] L2_REQ_DCACHE   = 2'd1;
    localparam logic [IDX_W-1:0] L2_REQ_PREFETCH = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } l2_arb_state_t;

    // Successor index with wrap at num-1.
    function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] idx,
                                                      input int num);
        return (int'(idx) >= num - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_req_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : l2_req_arbiter_rr_picker
// Description : Combinational rotating-priority picker: first requester found
//               scanning from i_ptr upward, modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_req_arbiter_rr_picker
    import l2_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
)
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_valid && i_req[j] && (w_sum == SUM_W'(j))) begin
                    o_valid    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_req_arbiter
// Description : Arbiter/sequencer for the shared L2 port (I$, D$, prefetcher).
//               Define L2_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int BLOCK_W = 128
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         req_resp,
    output logic [BLOCK_W-1:0]         req_rdata,
    output logic [ADDR_W-1:0]          l2_address,
    output logic [BLOCK_W-1:0]         l2_wdata,
    output logic                       l2_read,
    output logic                       l2_write,
    input  logic [BLOCK_W-1:0]         l2_rdata,
    input  logic                       l2_resp,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id
);

    l2_arb_state_t        r_state_q, w_state_d;
    logic [IDX_W-1:0]     r_grant_q, w_grant_d;
    logic [ADDR_W-1:0]    r_addr_q,  w_addr_d;
    logic [BLOCK_W-1:0]   r_wdata_q, w_wdata_d;
    logic                 r_read_q,  w_read_d;
    logic                 r_write_q, w_write_d;

    logic [NUM_REQ-1:0]   w_valid;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_any;
    logic [IDX_W-1:0]     w_ptr;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [BLOCK_W-1:0]   w_sel_wdata;
    logic                 w_sel_write;

    assign w_valid = req_read | req_write;

`ifdef L2_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr_q, w_rr_ptr_d;

    // Pointer moves past the last winner only once its transaction retires.
    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (r_state_q == RELEASE) begin
            w_rr_ptr_d = idx_wrap_inc(r_grant_q, NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr_q <= '0;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_ptr = r_rr_ptr_q;
`endif

    l2_req_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (w_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_win_onehot),
        .o_idx   (w_win_idx),
        .o_valid (w_win_any)
    );

    // One-hot AND-OR mux of the winning requester's slot; write wins over read.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win_onehot[j]) begin
                w_sel_addr  = w_sel_addr  | req_address[j*ADDR_W +: ADDR_W];
                w_sel_wdata = w_sel_wdata | req_wdata[j*BLOCK_W +: BLOCK_W];
                w_sel_write = w_sel_write | req_write[j];
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_read_d  = r_read_q;
        w_write_d = r_write_q;
        case (r_state_q)
            IDLE: begin
                if (w_win_any) begin
                    w_state_d = ACCESS;
                    w_grant_d = w_win_idx;
                    w_addr_d  = w_sel_addr;
                    w_wdata_d = w_sel_wdata;
                    w_write_d = w_sel_write;
                    w_read_d  = !w_sel_write;
                end
            end
            ACCESS: begin
                if (l2_resp) begin
                    w_state_d = RELEASE;
                    w_read_d  = 1'b0;
                    w_write_d = 1'b0;
                end
            end
            RELEASE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
                w_read_d  = 1'b0;
                w_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_grant_q <= L2_REQ_ICACHE;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_read_q  <= 1'b0;
            r_write_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_read_q  <= w_read_d;
            r_write_q <= w_write_d;
        end
    end

    // Completion is routed only to the current owner, in the l2_resp cycle.
    always_comb begin
        req_resp = '0;
        if ((r_state_q == ACCESS) && l2_resp) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (r_grant_q == IDX_W'(j)) begin
                    req_resp[j] = 1'b1;
                end
            end
        end
    end

    assign req_rdata  = l2_rdata;
    assign l2_address = r_addr_q;
    assign l2_wdata   = r_wdata_q;
    assign l2_read    = r_read_q;
    assign l2_write   = r_write_q;
    assign busy       = (r_state_q != IDLE);
    assign grant_id   = r_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_req_arbiter
// Description : Directed self-checking bench for l2_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_req_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int BW   = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_read;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ*BW-1:0] req_wdata;
    logic [NREQ-1:0]   req_resp;
    logic [BW-1:0]     req_rdata;
    logic [AW-1:0]     l2_address;
    logic [BW-1:0]     l2_wdata;
    logic              l2_read;
    logic              l2_write;
    logic [BW-1:0]     l2_rdata;
    logic              l2_resp;
    logic              busy;
    logic [1:0]        grant_id;

    int checks   = 0;
    int failures = 0;

    bit          s_seen;
    logic [1:0]  s_gid;
    logic        s_rs, s_ws;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_wd, s_rdat;
    logic [NREQ-1:0] s_resp;

    l2_req_arbiter #(
        .NUM_REQ (NREQ),
        .ADDR_W  (AW),
        .BLOCK_W (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_resp    (req_resp),
        .req_rdata   (req_rdata),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // L2 responder: waits for a strobe, captures it, answers after lat cycles.
    task automatic serve(input int lat, input logic [BW-1:0] rd,
                         output bit seen, output logic [1:0] gid,
                         output logic rs, output logic ws,
                         output logic [AW-1:0] addr, output logic [BW-1:0] wd,
                         output logic [NREQ-1:0] resp, output logic [BW-1:0] rdat);
        seen = 1'b0; gid = '0; rs = 1'b0; ws = 1'b0;
        addr = '0; wd = '0; resp = '0; rdat = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (l2_read || l2_write) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            gid = grant_id; rs = l2_read; ws = l2_write;
            addr = l2_address; wd = l2_wdata;
            repeat (lat) @(negedge clk);
            l2_rdata = rd;
            l2_resp  = 1'b1;
            #1;
            resp = req_resp;
            rdat = req_rdata;
            @(negedge clk);
            l2_resp = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if ({l2_read, l2_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b expected 00", {l2_read, l2_write}); end
        checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL reset_resp: got %b expected 000", req_resp); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if (l2_address !== 16'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", l2_address); end
        checks++; if (l2_wdata !== 128'h0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", l2_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req_address[0*AW +: AW] = 16'h1230;
        req_read = 3'b001;
        @(negedge clk); #1;
        checks++; if ({l2_read, l2_write} !== 2'b10) begin failures++; $display("FAIL single_strobe: got %b expected 10", {l2_read, l2_write}); end
        checks++; if (l2_address !== 16'h1230) begin failures++; $display("FAIL single_addr: got %h expected 1230", l2_address); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b expected 1", busy); end
        repeat (3) @(negedge clk);
        checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL single_early_resp: got %b expected 000", req_resp); end
        l2_rdata = {16{8'hA5}};
        l2_resp  = 1'b1;
        #1;
        checks++; if (req_resp !== 3'b001) begin failures++; $display("FAIL single_resp: got %b expected 001", req_resp); end
        checks++; if (req_rdata !== {16{8'hA5}}) begin failures++; $display("FAIL single_rdata: got %h expected a5..a5", req_rdata); end
        @(negedge clk);
        l2_resp = 1'b0; req_read = '0;
        #1;
        checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL single_resp_pulse: got %b expected 000", req_resp); end
        checks++; if ({l2_read, busy} !== 2'b01) begin failures++; $display("FAIL single_release: got read,busy=%b expected 01", {l2_read, busy}); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        req_address[0*AW +: AW] = 16'h1000;
        req_address[1*AW +: AW] = 16'h2222;
        req_wdata[1*BW +: BW]   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        req_read  = 3'b001;
        req_write = 3'b010;
        serve(2, 128'h5A5A, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
        req_read = '0;
        checks++; if (!s_seen) begin failures++; $display("FAIL sim_first_timeout: got no strobe expected strobe"); end
        checks++; if ({s_gid, s_rs, s_ws} !== 4'b00_10) begin failures++; $display("FAIL sim_first_grant: got gid=%0d rd=%0b wr=%0b expected gid=0 rd=1 wr=0", s_gid, s_rs, s_ws); end
        checks++; if (s_addr !== 16'h1000 || s_resp !== 3'b001) begin failures++; $display("FAIL sim_first_xact: got addr=%h resp=%b expected 1000 001", s_addr, s_resp); end
        checks++; if (s_rdat !== 128'h5A5A) begin failures++; $display("FAIL sim_first_rdata: got %h expected 5a5a", s_rdat); end
        serve(3, '0, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
        req_write = '0;
        checks++; if (!s_seen) begin failures++; $display("FAIL sim_second_timeout: got no strobe expected strobe"); end
        checks++; if ({s_gid, s_rs, s_ws} !== 4'b01_01) begin failures++; $display("FAIL sim_second_grant: got gid=%0d rd=%0b wr=%0b expected gid=1 rd=0 wr=1", s_gid, s_rs, s_ws); end
        checks++; if (s_addr !== 16'h2222 || s_resp !== 3'b010) begin failures++; $display("FAIL sim_second_xact: got addr=%h resp=%b expected 2222 010", s_addr, s_resp); end
        checks++; if (s_wd !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE) begin failures++; $display("FAIL sim_second_wdata: got %h", s_wd); end
        @(negedge clk); #1;
        checks++; if ({busy, grant_id} !== 3'b0_01) begin failures++; $display("FAIL sim_idle_hold: got busy=%0b gid=%0d expected 0 1", busy, grant_id); end
    endtask

    task automatic test_fairness();
        logic [1:0]    e;
        logic [AW-1:0] ea;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) req_address[i*AW +: AW] = 16'h0100 + 16'(i) * 16'h0101;
        req_read = 3'b111;
`ifdef L2_ARB_FIXED_PRIO_EN
        for (int n = 0; n < 4; n++) begin
            e = (n < 3) ? 2'd0 : 2'd1;
            serve(1, '0, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
            if (n == 2) req_read[0] = 1'b0;
`else
        for (int n = 0; n < 6; n++) begin
            e = 2'(n % 3);
            serve(1, '0, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
`endif
            ea = 16'h0100 + 16'(e) * 16'h0101;
            checks++; if (!s_seen || s_gid !== e) begin failures++; $display("FAIL fair_grant[%0d]: got seen=%0b gid=%0d expected gid=%0d", n, s_seen, s_gid, e); end
            checks++; if (s_addr !== ea || s_resp !== (3'b001 << e)) begin failures++; $display("FAIL fair_xact[%0d]: got addr=%h resp=%b expected %h %b", n, s_addr, s_resp, ea, 3'b001 << e); end
        end
        req_read = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rw_both();
        do_reset();
        @(negedge clk);
        req_address[1*AW +: AW] = 16'h3456;
        req_wdata[1*BW +: BW]   = {8{16'h1357}};
        req_read  = 3'b010;
        req_write = 3'b010;
        serve(2, '0, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
        req_read = '0; req_write = '0;
        checks++; if (!s_seen || {s_rs, s_ws} !== 2'b01) begin failures++; $display("FAIL rw_strobes: got seen=%0b rd=%0b wr=%0b expected 1 0 1", s_seen, s_rs, s_ws); end
        checks++; if (s_addr !== 16'h3456 || s_wd !== {8{16'h1357}}) begin failures++; $display("FAIL rw_payload: got addr=%h wd=%h", s_addr, s_wd); end
        checks++; if (s_resp !== 3'b010 || s_gid !== 2'd1) begin failures++; $display("FAIL rw_resp: got resp=%b gid=%0d expected 010 1", s_resp, s_gid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        bit seen = 1'b0;
        @(negedge clk);
        req_address[2*AW +: AW] = 16'h4444;
        req_read = 3'b100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (l2_read) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || grant_id !== 2'd2) begin failures++; $display("FAIL rst_mid_grant: got seen=%0b gid=%0d expected 1 2", seen, grant_id); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if ({l2_read, busy} !== 2'b00 || grant_id !== 2'd0) begin failures++; $display("FAIL rst_mid_state: got read=%0b busy=%0b gid=%0d expected 0 0 0", l2_read, busy, grant_id); end
        rst = 1'b0;
        req_read = '0;
        l2_resp = 1'b1;
        #1;
        checks++; if (req_resp !== 3'b000) begin failures++; $display("FAIL rst_stale_resp: got %b expected 000", req_resp); end
        @(negedge clk);
        l2_resp = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_stale_busy: got %0b expected 0", busy); end
        req_address[0*AW +: AW] = 16'h0AAA;
        req_read = 3'b111;
        serve(1, '0, s_seen, s_gid, s_rs, s_ws, s_addr, s_wd, s_resp, s_rdat);
        req_read = '0;
        checks++; if (!s_seen || s_gid !== 2'd0 || s_resp !== 3'b001) begin failures++; $display("FAIL rst_ptr_cleared: got seen=%0b gid=%0d resp=%b expected 1 0 001", s_seen, s_gid, s_resp); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_rw_both();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
